// File: rtl/fp_sqrt_unpack_pkg.sv
// Shared single-precision FPU constants, FSM state type and field-unpack helper
// for the square-root operand path.
package fp_sqrt_unpack_pkg;

  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [31:0] PINF   = 32'h7F80_0000;
  localparam int          BIAS   = 127;
  localparam int          EXP_W  = 8;
  localparam int          FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    OUT
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
    logic normal;
    logic sign;
  } fp_class_t;

  function automatic fp32_t unpack_fp32(input logic [31:0] f);
    return fp32_t'(f);
  endfunction

endpackage

// File: rtl/fp_special_detect.sv
// Combinational classification of a single-precision operand into
// nan / inf / zero / denormal / normal plus its sign.
module fp_special_detect
  import fp_sqrt_unpack_pkg::*;
(
  input  logic [31:0] in_float,
  output fp_class_t   cls
);

  fp32_t f;
  logic  exp_max;
  logic  exp_zero;
  logic  frac_nz;

  assign f        = unpack_fp32(in_float);
  assign exp_max  = &f.exp;
  assign exp_zero = ~|f.exp;
  assign frac_nz  = |f.frac;

  always_comb begin
    cls        = '0;
    cls.nan    = exp_max & frac_nz;
    cls.inf    = exp_max & ~frac_nz;
    cls.zero   = exp_zero & ~frac_nz;
    cls.denorm = exp_zero & frac_nz;
    cls.normal = ~exp_max & ~exp_zero;
    cls.sign   = f.sign;
  end

endmodule

// File: rtl/fp_sqrt_unpack.sv
// Operand stage for FP sqrt: resolves special cases, normalises denormals one bit
// per cycle, and emits an integer radicand plus biased result exponent.
module fp_sqrt_unpack
  import fp_sqrt_unpack_pkg::*;
#(
  parameter int RAD_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RAD_W-1:0] radicand,
  output logic [7:0]       res_exp,
  output logic             special,
  output logic [31:0]      special_val
);

  localparam int PAD = RAD_W - 48;

  state_t             state;
  state_t             state_nxt;
  logic [23:0]        mant;
  logic signed [9:0]  e;
  logic [23:0]        mant_sh;
  logic signed [9:0]  e_sh;
  logic signed [9:0]  e_unb;
  fp32_t              op;
  fp_class_t          cls;
  logic               accept;
  logic               is_special;
  logic [31:0]        spec_val;

  fp_special_detect u_detect (
    .in_float (in_float),
    .cls      (cls)
  );

  // An odd exponent folds its extra factor of two into the radicand so the
  // halved exponent stays integral; the radicand root then has bit 23 set.
  function automatic logic [RAD_W-1:0] form_radicand(input logic [23:0] m,
                                                     input logic signed [9:0] ex);
    logic [RAD_W-1:0] r;
    r = {{(RAD_W-24){1'b0}}, m};
    r = ex[0] ? (r << 24) : (r << 23);
    return r << PAD;
  endfunction

  function automatic logic [7:0] form_exp(input logic signed [9:0] ex);
    logic signed [9:0] h;
    h = (ex >>> 1) + 10'(BIAS);
    return h[7:0];
  endfunction

  assign op         = unpack_fp32(in_float);
  assign e_unb      = $signed({2'b00, op.exp}) - 10'(BIAS);
  assign mant_sh    = mant << 1;
  assign e_sh       = e - 10'sd1;
  assign accept     = in_valid && in_ready;
  assign is_special = cls.nan | cls.inf | cls.zero | (cls.sign & ~cls.zero);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == OUT);

  always_comb begin
    spec_val = {op.sign, 31'b0};
    if (cls.nan)                     spec_val = QNAN;
    else if (cls.sign && !cls.zero)  spec_val = QNAN;
    else if (cls.inf)                spec_val = PINF;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (is_special || cls.normal) ? OUT : NORM;
      NORM: if (mant_sh[23]) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant        <= '0;
      e           <= '0;
      radicand    <= '0;
      res_exp     <= '0;
      special     <= 1'b0;
      special_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_special) begin
              mant        <= '0;
              e           <= '0;
              radicand    <= '0;
              res_exp     <= '0;
              special     <= 1'b1;
              special_val <= spec_val;
            end else if (cls.normal) begin
              mant        <= {1'b1, op.frac};
              e           <= e_unb;
              radicand    <= form_radicand({1'b1, op.frac}, e_unb);
              res_exp     <= form_exp(e_unb);
              special     <= 1'b0;
              special_val <= '0;
            end else begin
              mant        <= {1'b0, op.frac};
              e           <= -10'sd126;
              special     <= 1'b0;
              special_val <= '0;
            end
          end
        end
        NORM: begin
          mant <= mant_sh;
          e    <= e_sh;
          // Result is formed from the shifted value in the same cycle it normalises.
          if (mant_sh[23]) begin
            radicand <= form_radicand(mant_sh, e_sh);
            res_exp  <= form_exp(e_sh);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
